// File: rtl/serial_pkg.sv
// Shared line-protocol definitions for the serial frame receiver and transmitter.
package serial_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;
endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Word and error flags are registered and qualified by a one-cycle data_valid pulse.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] din_msb;
  logic [DATA_W-1:0] shreg_nxt;
  logic              err_p;

  // Right shift with the new bit entering at the MSB; works for DATA_W=1 too.
  always_comb begin
    din_msb = '0;
    din_msb[DATA_W-1] = din;
    shreg_nxt = (shreg >> 1) | din_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      err_p      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (din != LINE_IDLE) begin
            state <= DATA;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shreg <= shreg_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1))
            state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          err_p <= ^{shreg, din};
          state <= STOP;
        end
        STOP: begin
          data_out   <= shreg;
          data_valid <= 1'b1;
          parity_err <= (PARITY_EN != 0) ? err_p : 1'b0;
          frame_err  <= ~din;
          state      <= IDLE;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed frames with hand-computed expectations; a scoreboard monitor checks every data_valid.
module tb_serial_frame_rx;
  typedef struct {
    logic [15:0] d;
    logic        pe;
    logic        fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din, din4;
  logic [7:0] data_out;
  logic [3:0] data_out4;
  logic       data_valid, parity_err, frame_err, busy;
  logic       data_valid4, parity_err4, frame_err4, busy4;

  exp_t q[$];
  exp_t q4[$];
  int   vcyc[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .din(din), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  serial_frame_rx #(.DATA_W(4), .PARITY_EN(0)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .data_out(data_out4), .data_valid(data_valid4),
    .parity_err(parity_err4), .frame_err(frame_err4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  // Scoreboard monitor for the 8-bit parity instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(data_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d[7:0]));
          chk("parity_err", 32'(parity_err), 32'(e.pe));
          chk("frame_err", 32'(frame_err), 32'(e.fe));
          vcyc.push_back(cyc);
        end
      end else begin
        chk("flags_unqualified", 32'({parity_err, frame_err}), 32'd0);
      end
    end
  end

  // Scoreboard monitor for the 4-bit no-parity instance.
  always @(negedge clk) begin
    if (!rst && data_valid4) begin
      if (q4.size() == 0) begin
        chk("spurious_valid4", 32'(data_valid4), 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("data_out4", 32'(data_out4), 32'(e.d[3:0]));
        chk("parity_err4", 32'(parity_err4), 32'(e.pe));
        chk("frame_err4", 32'(frame_err4), 32'(e.fe));
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic exp_pe, input logic exp_fe);
    exp_t e;
    e.d = {8'h00, d};
    e.pe = exp_pe;
    e.fe = exp_fe;
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    logic [5:0] bits4;
    exp_t e4;
    rst = 1'b1;
    din = 1'b1;
    din4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_flags", 32'({parity_err, frame_err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(2);

    // 0xA5 has four ones, so the even-parity bit is 0.
    busy_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("busy_cycles", 32'(busy_cnt), 32'd10);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(15);

    // Back to back: 0x01 and 0xFE both carry parity bit 1.
    vcyc.delete();
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("b2b_count", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) chk("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'd11);

    // Abort after the 4th data bit.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    idle(12);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // 4-bit, no parity: start, 1,1,0,1, stop -> 4'hB.
    bits4 = 6'b110110;
    e4.d = 16'h000B;
    e4.pe = 1'b0;
    e4.fe = 1'b0;
    q4.push_back(e4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din4 = bits4[i];
    end
    @(negedge clk);
    din4 = 1'b1;
    chk("dw4_valid_next", 32'(data_valid4), 32'd1);
    chk("dw4_parity_zero", 32'(parity_err4), 32'd0);
    @(negedge clk);
    chk("dw4_valid_pulse", 32'(data_valid4), 32'd0);

    for (int i = 0; i < 50 && (q.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size() + q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
